// File: rtl/lock_perm_pkg.sv
// Shared definitions for the lock permutation register file: op codes,
// FSM state encoding and the slot bit-offset helper.
package lock_perm_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_SWAP = 2'b01;
    localparam logic [1:0] OP_ROTL = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ROT  = 1'b1
    } permStateT;

    // Bit offset of slot idx inside a packed slot vector.
    function automatic int slotOffset(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/lock_perm_rot1.sv
// Combinational single-step rotator over packed slots.
// Left step:  out[i] = in[(i+1) mod N]
// Right step: out[i] = in[(i-1) mod N]
module lock_perm_rot1
    import lock_perm_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter int NUM_SLOTS = 3
) (
    input  logic [NUM_SLOTS*WIDTH-1:0] slotsIn,
    input  logic                       dirRight,
    output logic [NUM_SLOTS*WIDTH-1:0] slotsOut
);

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : gSlot
        localparam int NEXT = (i + 1) % NUM_SLOTS;
        localparam int PREV = (i + NUM_SLOTS - 1) % NUM_SLOTS;
        assign slotsOut[slotOffset(i, WIDTH) +: WIDTH] = dirRight
            ? slotsIn[slotOffset(PREV, WIDTH) +: WIDTH]
            : slotsIn[slotOffset(NEXT, WIDTH) +: WIDTH];
    end

endmodule

// File: rtl/lock_perm_regfile.sv
// Scramble register file: holds NUM_SLOTS symbols and applies a stream of
// swap / rotate ops to its own contents. Multi-step rotates run one step per
// cycle through a single shared rotator while the FSM sits in ST_ROT.
//
// Handshake: an op transfers on a rising CLK edge where op_valid_i and
// op_ready_o are both high. op_ready_o depends only on the FSM state, the
// op-count limit and load_i, never on op_valid_i; the requester holds op
// fields stable while op_valid_i is high and not yet accepted.
module lock_perm_regfile
    import lock_perm_pkg::*;
#(
    parameter  int WIDTH     = 5,
    parameter  int NUM_SLOTS = 3,
    parameter  int MAX_OPS   = 15,
    localparam int IDX_W     = $clog2(NUM_SLOTS),
    localparam int CNT_W     = $clog2(MAX_OPS + 1)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       load_i,
    input  logic [NUM_SLOTS*WIDTH-1:0] load_data_i,
    input  logic                       op_valid_i,
    output logic                       op_ready_o,
    input  logic [1:0]                 op_code_i,
    input  logic [IDX_W-1:0]           op_a_i,
    input  logic [IDX_W-1:0]           op_b_i,
    output logic [NUM_SLOTS*WIDTH-1:0] slots_o,
    output logic                       busy_o,
    output logic [CNT_W-1:0]           op_count_o,
    output logic                       limit_o,
    output logic                       err_o
);

    // One extra bit so NUM_SLOTS itself is representable for range checks.
    localparam logic [IDX_W:0]   NSLOTS  = (IDX_W + 1)'(NUM_SLOTS);
    localparam logic [IDX_W:0]   TWO     = (IDX_W + 1)'(2);
    localparam logic [IDX_W-1:0] ONE_IDX = IDX_W'(1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPS);

    permStateT                state, stateNext;
    logic [NUM_SLOTS*WIDTH-1:0] slotsQ, slotsNext;
    logic [CNT_W-1:0]           countQ, countNext;
    logic                       errQ, errNext;
    logic [IDX_W-1:0]           remainQ, remainNext;
    logic                       dirQ, dirNext;

    logic [NUM_SLOTS*WIDTH-1:0] rotOut;
    logic                       rotDirRight;
    logic [IDX_W:0]             aExt, bExt;
    logic                       aInRange, bInRange, opLegal, accept;

    assign aExt     = {1'b0, op_a_i};
    assign bExt     = {1'b0, op_b_i};
    assign aInRange = aExt < NSLOTS;
    assign bInRange = bExt < NSLOTS;
    assign opLegal  = (op_code_i == OP_NOP)  ? 1'b1 :
                      (op_code_i == OP_SWAP) ? (aInRange && bInRange) :
                                               aInRange;

    assign limit_o    = (countQ == MAX_CNT);
    assign op_ready_o = (state == ST_IDLE) && !limit_o && !load_i;
    assign accept     = op_valid_i && op_ready_o;

    // In ROT the latched direction drives the rotator; in IDLE the incoming op does.
    assign rotDirRight = (state == ST_ROT) ? dirQ : (op_code_i == OP_ROTR);

    lock_perm_rot1 #(
        .WIDTH    (WIDTH),
        .NUM_SLOTS(NUM_SLOTS)
    ) uRot1 (
        .slotsIn (slotsQ),
        .dirRight(rotDirRight),
        .slotsOut(rotOut)
    );

    // Next-state logic: load wins, then IDLE op execution or one ROT step.
    always_comb begin
        stateNext  = state;
        slotsNext  = slotsQ;
        countNext  = countQ;
        errNext    = errQ;
        remainNext = remainQ;
        dirNext    = dirQ;

        if (load_i) begin
            slotsNext  = load_data_i;
            countNext  = '0;
            errNext    = 1'b0;
            remainNext = '0;
            stateNext  = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (!opLegal) begin
                            errNext = 1'b1;
                        end else begin
                            countNext = countQ + CNT_W'(1);
                            case (op_code_i)
                                OP_SWAP: begin
                                    slotsNext[slotOffset(int'(op_a_i), WIDTH) +: WIDTH] =
                                        slotsQ[slotOffset(int'(op_b_i), WIDTH) +: WIDTH];
                                    slotsNext[slotOffset(int'(op_b_i), WIDTH) +: WIDTH] =
                                        slotsQ[slotOffset(int'(op_a_i), WIDTH) +: WIDTH];
                                end
                                OP_ROTL, OP_ROTR: begin
                                    if (op_a_i != '0) begin
                                        slotsNext = rotOut;
                                    end
                                    if (aExt >= TWO) begin
                                        stateNext  = ST_ROT;
                                        remainNext = op_a_i - ONE_IDX;
                                        dirNext    = (op_code_i == OP_ROTR);
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_ROT: begin
                    slotsNext  = rotOut;
                    remainNext = remainQ - ONE_IDX;
                    if (remainQ == ONE_IDX) begin
                        stateNext = ST_IDLE;
                    end
                end
                default: stateNext = ST_IDLE;
            endcase
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            slotsQ  <= '0;
            countQ  <= '0;
            errQ    <= 1'b0;
            remainQ <= '0;
            dirQ    <= 1'b0;
        end else begin
            state   <= stateNext;
            slotsQ  <= slotsNext;
            countQ  <= countNext;
            errQ    <= errNext;
            remainQ <= remainNext;
            dirQ    <= dirNext;
        end
    end

    assign slots_o    = slotsQ;
    assign busy_o     = (state == ST_ROT);
    assign op_count_o = countQ;
    assign err_o      = errQ;

endmodule

// File: tb/tb_lock_perm_regfile.sv
// Directed bench for lock_perm_regfile (WIDTH=5, NUM_SLOTS=3, MAX_OPS=15).
module tb_lock_perm_regfile;

    localparam int WIDTH     = 5;
    localparam int NUM_SLOTS = 3;
    localparam int MAX_OPS   = 15;
    localparam int IDX_W     = $clog2(NUM_SLOTS);
    localparam int CNT_W     = $clog2(MAX_OPS + 1);
    localparam int SW        = NUM_SLOTS * WIDTH;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             load_i = 1'b0;
    logic [SW-1:0]    load_data_i = '0;
    logic             op_valid_i = 1'b0;
    logic             op_ready_o;
    logic [1:0]       op_code_i = 2'b00;
    logic [IDX_W-1:0] op_a_i = '0;
    logic [IDX_W-1:0] op_b_i = '0;
    logic [SW-1:0]    slots_o;
    logic             busy_o;
    logic [CNT_W-1:0] op_count_o;
    logic             limit_o;
    logic             err_o;

    int checkCount = 0;
    int errorCount = 0;
    logic [SW-1:0] expQ[$];

    lock_perm_regfile #(
        .WIDTH    (WIDTH),
        .NUM_SLOTS(NUM_SLOTS),
        .MAX_OPS  (MAX_OPS)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .load_i     (load_i),
        .load_data_i(load_data_i),
        .op_valid_i (op_valid_i),
        .op_ready_o (op_ready_o),
        .op_code_i  (op_code_i),
        .op_a_i     (op_a_i),
        .op_b_i     (op_b_i),
        .slots_o    (slots_o),
        .busy_o     (busy_o),
        .op_count_o (op_count_o),
        .limit_o    (limit_o),
        .err_o      (err_o)
    );

    // Clock
    always #5 CLK = ~CLK;

    function automatic logic [SW-1:0] pack3(input int s0, input int s1, input int s2);
        return {WIDTH'(s2), WIDTH'(s1), WIDTH'(s0)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare slots_o against the oldest expected slot image.
    task automatic checkSlots(input string tag);
        logic [SW-1:0] exp;
        exp = (expQ.size() > 0) ? expQ.pop_front() : '1;
        check(tag, 32'(slots_o), 32'(exp));
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic doLoad(input logic [SW-1:0] data);
        load_i      = 1'b1;
        load_data_i = data;
        step();
        load_i = 1'b0;
        #1;
    endtask

    task automatic driveOp(input logic [1:0] code, input int a, input int b);
        op_valid_i = 1'b1;
        op_code_i  = code;
        op_a_i     = IDX_W'(a);
        op_b_i     = IDX_W'(b);
    endtask

    task automatic idleOp();
        op_valid_i = 1'b0;
        #1;
    endtask

    initial begin
        // Reset
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        #1;
        expQ.push_back('0);
        checkSlots("reset_slots");
        check("reset_count", 32'(op_count_o), 0);
        check("reset_err", 32'(err_o), 0);
        check("reset_busy", 32'(busy_o), 0);
        check("reset_ready", 32'(op_ready_o), 1);

        // 1. Load
        load_i = 1'b1;
        load_data_i = pack3(1, 2, 3);
        #1;
        check("ready_low_during_load", 32'(op_ready_o), 0);
        step();
        load_i = 1'b0;
        #1;
        expQ.push_back(pack3(1, 2, 3));
        checkSlots("load_slots");
        check("load_count", 32'(op_count_o), 0);
        check("load_err", 32'(err_o), 0);
        check("load_ready", 32'(op_ready_o), 1);

        // 2. SWAP 0,2
        driveOp(2'b01, 0, 2);
        step();
        idleOp();
        expQ.push_back(pack3(3, 2, 1));
        checkSlots("swap02_slots");
        check("swap02_count", 32'(op_count_o), 1);
        check("swap02_busy", 32'(busy_o), 0);

        // 3a. ROTL 1
        doLoad(pack3(1, 2, 3));
        driveOp(2'b10, 1, 0);
        step();
        idleOp();
        expQ.push_back(pack3(2, 3, 1));
        checkSlots("rotl1_slots");
        check("rotl1_busy", 32'(busy_o), 0);
        check("rotl1_count", 32'(op_count_o), 1);

        // 3b. ROTR 2
        doLoad(pack3(1, 2, 3));
        driveOp(2'b11, 2, 0);
        step();
        idleOp();
        expQ.push_back(pack3(3, 1, 2));
        checkSlots("rotr2_step1_slots");
        check("rotr2_step1_busy", 32'(busy_o), 1);
        check("rotr2_step1_ready", 32'(op_ready_o), 0);
        step();
        expQ.push_back(pack3(2, 3, 1));
        checkSlots("rotr2_step2_slots");
        check("rotr2_step2_busy", 32'(busy_o), 0);
        check("rotr2_step2_count", 32'(op_count_o), 1);
        check("rotr2_step2_ready", 32'(op_ready_o), 1);

        // 3c. ROTL 0: counted, no change
        driveOp(2'b10, 0, 0);
        step();
        idleOp();
        expQ.push_back(pack3(2, 3, 1));
        checkSlots("rotl0_slots");
        check("rotl0_count", 32'(op_count_o), 2);
        check("rotl0_busy", 32'(busy_o), 0);

        // 4. Illegal SWAP 3,0
        driveOp(2'b01, 3, 0);
        #1;
        check("illegal_ready", 32'(op_ready_o), 1);
        step();
        idleOp();
        expQ.push_back(pack3(2, 3, 1));
        checkSlots("illegal_slots");
        check("illegal_err", 32'(err_o), 1);
        check("illegal_count", 32'(op_count_o), 2);
        driveOp(2'b00, 0, 0);
        step();
        idleOp();
        check("err_sticky", 32'(err_o), 1);
        check("nop_after_err_count", 32'(op_count_o), 3);
        driveOp(2'b10, 3, 0);
        step();
        idleOp();
        expQ.push_back(pack3(2, 3, 1));
        checkSlots("illegal_rot_slots");
        check("illegal_rot_count", 32'(op_count_o), 3);
        doLoad(pack3(4, 5, 6));
        check("load_clears_err", 32'(err_o), 0);
        check("load_clears_count", 32'(op_count_o), 0);

        // 5. Op limit
        driveOp(2'b00, 0, 0);
        for (int i = 0; i < MAX_OPS; i++) step();
        check("limit_count", 32'(op_count_o), MAX_OPS);
        check("limit_flag", 32'(limit_o), 1);
        check("limit_ready", 32'(op_ready_o), 0);
        step();
        step();
        check("limit_hold_count", 32'(op_count_o), MAX_OPS);
        load_i = 1'b1;
        step();
        load_i = 1'b0;
        op_valid_i = 1'b0;
        #1;
        check("limit_load_count", 32'(op_count_o), 0);
        check("limit_load_ready", 32'(op_ready_o), 1);
        check("limit_load_flag", 32'(limit_o), 0);

        // 6a. Load aborts rotate
        doLoad(pack3(1, 2, 3));
        driveOp(2'b11, 2, 0);
        step();
        check("abort_busy_before", 32'(busy_o), 1);
        driveOp(2'b01, 0, 1);
        load_i = 1'b1;
        load_data_i = pack3(7, 8, 9);
        #1;
        check("abort_ready", 32'(op_ready_o), 0);
        step();
        load_i = 1'b0;
        idleOp();
        expQ.push_back(pack3(7, 8, 9));
        checkSlots("abort_slots");
        check("abort_busy", 32'(busy_o), 0);
        check("abort_count", 32'(op_count_o), 0);

        // 6b. Reset mid-rotate
        driveOp(2'b11, 2, 0);
        step();
        idleOp();
        check("rst_busy_before", 32'(busy_o), 1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        #1;
        expQ.push_back('0);
        checkSlots("rst_mid_slots");
        check("rst_mid_busy", 32'(busy_o), 0);
        check("rst_mid_count", 32'(op_count_o), 0);
        check("rst_mid_err", 32'(err_o), 0);
        check("rst_mid_limit", 32'(limit_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
